// File: rtl/fir_frame_ctrl_if.sv
// Sample stream into the frame controller and tagged FIR output stream out of it.
// The master side feeds samples and observes outputs; the slave side is the controller.
interface fir_frame_ctrl_if #(
   parameter int WORD_SIZE = 10,
   parameter int OUT_W     = 12
);
   logic                        in_valid;
   logic                        in_ready;
   logic signed [WORD_SIZE-1:0] in_data;
   logic                        in_last;
   logic                        out_valid;
   logic signed [OUT_W-1:0]     out_data;
   logic                        out_last;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for a free-running pipelined FIR: feeds samples, flushes TAPS-1 zeros
// per frame and tags FIR outputs valid/last. FIR_FRAME_CTRL_STAT_EN adds frame/sample counters.
module fir_frame_ctrl #(
   parameter int WORD_SIZE = 10,
   parameter int OUT_W     = 12,
   parameter int TAPS      = 21,
   parameter int FIR_LAT   = 6,
   parameter int MAX_LEN   = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   fir_frame_ctrl_if.slave             s_if,
   output logic signed [WORD_SIZE-1:0] o_fir_in,
   input  logic signed [OUT_W-1:0]     i_fir_out,
   output logic                        o_busy,
   output logic                        o_err_underrun,
   output logic                        o_err_overlen,
   input  logic                        i_clr_err
`ifdef FIR_FRAME_CTRL_STAT_EN
   ,
   output logic [15:0]                 o_frame_cnt,
   output logic [15:0]                 o_sample_cnt
`endif
);

   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int FLUSH_W = $clog2(TAPS);
   localparam int PIPE    = FIR_LAT + 1;
   localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(TAPS - 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t                      r_state, w_next_state;
   logic signed [WORD_SIZE-1:0] r_fir_in, w_fir_in_nxt;
   logic [LEN_W-1:0]            r_len_cnt, w_len_nxt, w_len_inc;
   logic [FLUSH_W-1:0]          r_flush_cnt, w_flush_nxt;
   logic [PIPE-1:0]             r_tag_v, r_tag_l;
   logic                        w_tag_v, w_tag_l;
   logic                        r_out_valid, r_out_last;
   logic signed [OUT_W-1:0]     r_out_data;
   logic                        r_err_underrun, r_err_overlen;
   logic                        w_set_under, w_set_over;
   logic                        w_in_ready, w_accept;

   assign w_in_ready = (r_state != S_FLUSH);
   assign w_accept   = s_if.in_valid & w_in_ready;
   assign w_len_inc  = r_len_cnt + 1'b1;

   // NOTE: state register only here; all decisions live in the always_comb below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      w_fir_in_nxt = '0;
      w_tag_v      = 1'b0;
      w_tag_l      = 1'b0;
      w_len_nxt    = r_len_cnt;
      w_flush_nxt  = r_flush_cnt;
      w_set_under  = 1'b0;
      w_set_over   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_fir_in_nxt = s_if.in_data;
               w_tag_v      = 1'b1;
               w_len_nxt    = LEN_W'(1);
               w_flush_nxt  = '0;
               if (s_if.in_last || (MAX_LEN == 1)) begin
                  w_next_state = S_FLUSH;
                  w_set_over   = !s_if.in_last;
               end else begin
                  w_next_state = S_RUN;
               end
            end
         end
         S_RUN: begin
            // A missing sample is replaced by zero so the frame keeps one push per clock.
            w_tag_v   = 1'b1;
            w_len_nxt = w_len_inc;
            if (w_accept) w_fir_in_nxt = s_if.in_data;
            else          w_set_under  = 1'b1;
            if ((w_accept && s_if.in_last) || (w_len_inc == LEN_MAX)) begin
               w_next_state = S_FLUSH;
               w_flush_nxt  = '0;
               w_set_over   = !(w_accept && s_if.in_last);
            end
         end
         S_FLUSH: begin
            w_tag_v     = 1'b1;
            w_flush_nxt = r_flush_cnt + 1'b1;
            if (r_flush_cnt == FLUSH_LAST) begin
               w_tag_l      = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fir_in       <= '0;
         r_len_cnt      <= '0;
         r_flush_cnt    <= '0;
         r_tag_v        <= '0;
         r_tag_l        <= '0;
         r_out_valid    <= 1'b0;
         r_out_last     <= 1'b0;
         r_out_data     <= '0;
         r_err_underrun <= 1'b0;
         r_err_overlen  <= 1'b0;
      end else begin
         r_fir_in    <= w_fir_in_nxt;
         r_len_cnt   <= w_len_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_tag_v     <= {r_tag_v[PIPE-2:0], w_tag_v};
         r_tag_l     <= {r_tag_l[PIPE-2:0], w_tag_l};
         r_out_valid <= r_tag_v[PIPE-1];
         r_out_last  <= r_tag_v[PIPE-1] & r_tag_l[PIPE-1];
         r_out_data  <= i_fir_out;
         // A new error in the same cycle as clr_err keeps the flag set.
         if (w_set_under)    r_err_underrun <= 1'b1;
         else if (i_clr_err) r_err_underrun <= 1'b0;
         if (w_set_over)     r_err_overlen  <= 1'b1;
         else if (i_clr_err) r_err_overlen  <= 1'b0;
      end
   end

`ifdef FIR_FRAME_CTRL_STAT_EN
   logic [15:0] r_frame_cnt, r_sample_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt  <= '0;
         r_sample_cnt <= '0;
      end else begin
         if (r_tag_v[PIPE-1] && r_tag_l[PIPE-1]) r_frame_cnt <= r_frame_cnt + 1'b1;
         if (w_accept) r_sample_cnt <= r_sample_cnt + 1'b1;
      end
   end

   assign o_frame_cnt  = r_frame_cnt;
   assign o_sample_cnt = r_sample_cnt;
`endif

   assign s_if.in_ready  = w_in_ready;
   assign s_if.out_valid = r_out_valid;
   assign s_if.out_data  = r_out_data;
   assign s_if.out_last  = r_out_last;
   assign o_fir_in       = r_fir_in;
   assign o_busy         = (r_state != S_IDLE) | (|r_tag_v);
   assign o_err_underrun = r_err_underrun;
   assign o_err_overlen  = r_err_overlen;

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Self-checking bench for fir_frame_ctrl with a behavioural 21-tap, 6-clock-latency FIR
// model closing the loop; frames are table-driven plus hand-written corner sequences.
module tb_fir_frame_ctrl;

   localparam int WORD_SIZE = 10;
   localparam int OUT_W     = 12;
   localparam int TAPS      = 21;
   localparam int FIR_LAT   = 6;
   localparam int MAX_LEN   = 8;

   localparam int H   [TAPS] = '{-1, 1, 3, 2, -1, -4, -4, 1, 10, 18, 21, 18, 10, 1, -4, -4, -1, 2, 3, 1, -1};
   localparam int IMP [TAPS] = '{-16, 16, 48, 32, -16, -64, -64, 16, 160, 288, 336, 288, 160,
                                 16, -64, -64, -16, 32, 48, 16, -16};

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        clr_err = 1'b0;
   logic signed [WORD_SIZE-1:0] fir_in;
   logic signed [OUT_W-1:0]     fir_out;
   logic                        busy, err_u, err_o;
`ifdef FIR_FRAME_CTRL_STAT_EN
   logic [15:0]                 frame_cnt, sample_cnt;
`endif

   fir_frame_ctrl_if #(.WORD_SIZE(WORD_SIZE), .OUT_W(OUT_W)) bus ();

   fir_frame_ctrl #(
      .WORD_SIZE(WORD_SIZE), .OUT_W(OUT_W), .TAPS(TAPS), .FIR_LAT(FIR_LAT), .MAX_LEN(MAX_LEN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_if           (bus),
      .o_fir_in       (fir_in),
      .i_fir_out      (fir_out),
      .o_busy         (busy),
      .o_err_underrun (err_u),
      .o_err_overlen  (err_o),
      .i_clr_err      (clr_err)
`ifdef FIR_FRAME_CTRL_STAT_EN
      ,
      .o_frame_cnt    (frame_cnt),
      .o_sample_cnt   (sample_cnt)
`endif
   );

   always #5 clk = ~clk;

   // FIR model: y_k for the sample written at edge k appears on fir_out after edge k+6.
   logic signed [WORD_SIZE-1:0] hist  [TAPS-1];
   logic signed [OUT_W-1:0]     fpipe [FIR_LAT];
   int                          y_comb;

   always_comb begin
      y_comb = H[0] * fir_in;
      for (int j = 1; j < TAPS; j++) y_comb += H[j] * hist[j-1];
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAPS-1; i++) hist[i] <= '0;
         for (int i = 0; i < FIR_LAT; i++) fpipe[i] <= '0;
      end else begin
         hist[0] <= fir_in;
         for (int i = 1; i < TAPS-1; i++) hist[i] <= hist[i-1];
         fpipe[0] <= y_comb[OUT_W-1:0];
         for (int i = 1; i < FIR_LAT; i++) fpipe[i] <= fpipe[i-1];
      end
   end
   assign fir_out = fpipe[FIR_LAT-1];

   // Output monitor, sampled on the falling edge.
   int cyc = 0;
   int got_q[$];
   int last_q[$];
   int first_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (got_q.size() == 0) first_cyc = cyc;
         if (bus.out_last) last_q.push_back(got_q.size());
         got_q.push_back(int'(bus.out_data));
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_out(input int x[$], input int n);
      int acc = 0;
      logic signed [OUT_W-1:0] t;
      for (int j = 0; j < TAPS; j++)
         if ((n - j) >= 0 && (n - j) < x.size()) acc += H[j] * x[n-j];
      t = acc[OUT_W-1:0];
      return int'(t);
   endfunction

   task automatic clear_mon();
      got_q.delete();
      last_q.delete();
      first_cyc = -1;
   endtask

   task automatic send(input int d, input bit last, output int waited);
      bus.in_valid = 1'b1;
      bus.in_data  = WORD_SIZE'(d);
      bus.in_last  = last;
      waited = 0;
      while (!bus.in_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_idle"}, busy, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
   endtask

   task automatic check_frame(input string name, input int x[$], input int base);
      for (int n = 0; n < x.size() + TAPS - 1; n++)
         if (base + n < got_q.size())
            check($sformatf("%s_y%0d", name, n), got_q[base+n], ref_out(x, n));
   endtask

   typedef struct {
      int n;
      int d[4];
      bit gap;        // one idle cycle after the second sample
      int exp_len;
      bit exp_under;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int w, acc_cyc;
      int x[$];
`ifdef FIR_FRAME_CTRL_STAT_EN
      int f0, s0;
`endif
      vecs[0] = '{1, '{16, 0, 0, 0}, 1'b0, 21, 1'b0};
      vecs[1] = '{3, '{-18, 17, 5, 0}, 1'b0, 23, 1'b0};
      vecs[2] = '{2, '{2, -3, 0, 0}, 1'b0, 22, 1'b0};
      vecs[3] = '{4, '{16, 16, 16, 16}, 1'b1, 25, 1'b1};

      idle_in();
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last",  bus.out_last, 0);
      check("rst_out_data",  bus.out_data, 0);
      check("rst_fir_in",    fir_in, 0);
      check("rst_busy",      busy, 0);
      check("rst_err_u",     err_u, 0);
      check("rst_err_o",     err_o, 0);
      check("rst_in_ready",  bus.in_ready, 1);
`ifdef FIR_FRAME_CTRL_STAT_EN
      check("rst_frame_cnt",  frame_cnt, 0);
      check("rst_sample_cnt", sample_cnt, 0);
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Impulse against the hand-computed response, with latency and last position.
      clear_mon();
      send(16, 1'b1, w);
      acc_cyc = cyc;
      idle_in();
      check("imp_busy", busy, 1);
      wait_idle("imp");
      check("imp_count", got_q.size(), 21);
      check("imp_latency", first_cyc - acc_cyc, 7);
      check("imp_nlast", last_q.size(), 1);
      if (last_q.size() > 0) check("imp_last_pos", last_q[0], 20);
      for (int i = 0; i < TAPS; i++)
         if (i < got_q.size()) check($sformatf("imp_y%0d", i), got_q[i], IMP[i]);

      // Table-driven single frames.
      for (int v = 0; v < 4; v++) begin
         pulse_clr();
         clear_mon();
         x.delete();
         for (int i = 0; i < vecs[v].n; i++) begin
            send(vecs[v].d[i], (i == vecs[v].n - 1), w);
            x.push_back(vecs[v].d[i]);
            if (vecs[v].gap && i == 1) begin
               idle_in();
               @(posedge clk); #1;
               x.push_back(0);
            end
         end
         idle_in();
         wait_idle($sformatf("vec%0d", v));
         check($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_len);
         check($sformatf("vec%0d_nlast", v), last_q.size(), 1);
         if (last_q.size() > 0)
            check($sformatf("vec%0d_last_pos", v), last_q[0], vecs[v].exp_len - 1);
         check($sformatf("vec%0d_err_u", v), err_u, int'(vecs[v].exp_under));
         check_frame($sformatf("vec%0d", v), x, 0);
      end

      // Underrun flag holds until clr_err.
      repeat (10) @(posedge clk);
      #1;
      check("under_hold", err_u, 1);
      pulse_clr();
      check("under_clr", err_u, 0);

      // Back-to-back frames of 3 and 2 samples.
`ifdef FIR_FRAME_CTRL_STAT_EN
      f0 = frame_cnt;
      s0 = sample_cnt;
`endif
      clear_mon();
      send(16, 1'b0, w);
      send(16, 1'b0, w);
      send(16, 1'b1, w);
      send(16, 1'b0, w);
      check("b2b_ready_gap", w, 20);
      send(16, 1'b1, w);
      idle_in();
      wait_idle("b2b");
      check("b2b_count", got_q.size(), 45);
      check("b2b_nlast", last_q.size(), 2);
      if (last_q.size() == 2) begin
         check("b2b_last0", last_q[0], 22);
         check("b2b_last1", last_q[1], 44);
      end
      x = '{16, 16, 16};
      check_frame("b2b_f0", x, 0);
      x = '{16, 16};
      check_frame("b2b_f1", x, 23);
`ifdef FIR_FRAME_CTRL_STAT_EN
      check("stat_frames",  int'(frame_cnt) - f0, 2);
      check("stat_samples", int'(sample_cnt) - s0, 5);
`endif

      // Overlength: 10 samples without in_last, frame cut at MAX_LEN=8.
      pulse_clr();
      clear_mon();
      for (int i = 1; i <= 8; i++) begin
         send(i, 1'b0, w);
         check($sformatf("ovl_nowait%0d", i), w, 0);
      end
      send(9, 1'b0, w);
      check("ovl_ready_gap", w, 20);
      check("ovl_err_o", err_o, 1);
      check("ovl_err_u_clean", err_u, 0);
      send(10, 1'b0, w);
      idle_in();
      wait_idle("ovl");
      check("ovl_count", got_q.size(), 56);
      check("ovl_nlast", last_q.size(), 2);
      if (last_q.size() == 2) begin
         check("ovl_last0", last_q[0], 27);
         check("ovl_last1", last_q[1], 55);
      end
      check("ovl_err_u_fill", err_u, 1);
      x = '{1, 2, 3, 4, 5, 6, 7, 8};
      check_frame("ovl_f0", x, 0);
      x = '{9, 10, 0, 0, 0, 0, 0, 0};
      check_frame("ovl_f1", x, 28);

      // Clear racing with a new error: the set wins.
      pulse_clr();
      clear_mon();
      send(5, 1'b0, w);
      clr_err = 1'b1;
      idle_in();
      @(posedge clk); #1;
      clr_err = 1'b0;
      check("clr_vs_set", err_u, 1);
      wait_idle("race");

      // Reset mid-FLUSH drops the partial frame.
      pulse_clr();
      clear_mon();
      send(16, 1'b1, w);
      idle_in();
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_fir_in", fir_in, 0);
      clear_mon();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_quiet", got_q.size(), 0);
      send(16, 1'b1, w);
      acc_cyc = cyc;
      idle_in();
      wait_idle("post_rst");
      check("post_rst_count", got_q.size(), 21);
      check("post_rst_latency", first_cyc - acc_cyc, 7);
      for (int i = 0; i < TAPS; i++)
         if (i < got_q.size()) check($sformatf("post_rst_y%0d", i), got_q[i], IMP[i]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
